// File: rtl/rate_capture_ack.sv
// rate_capture_ack
//   Downstream consumer for a DSP timed counter running in acknowledge mode.
//   Captures each completed interval count and returns a one-cycle acknowledge
//   that restarts the counter. The count is presented on a valid/ready output
//   slot. Alongside the capture it keeps a power-of-two interval average, a
//   sticky overrun flag and a hysteretic rate alarm.
//
// Parameters
//   AVG_LOG2      average over 2^AVG_LOG2 captures (0..8)
//   BACKPRESSURE  "TRUE"  : withhold the acknowledge until the output slot is free
//                 "FALSE" : overwrite the slot and flag an overrun
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   enable               captures allowed only while high
//   count_in             interval count from the counter
//   count_valid_in       counter's level-held valid
//   count_ack            one-cycle acknowledge pulse (drives counter rst)
//   m_tdata / m_tvalid   output slot; m_tready is the consumer accept
//   avg_out / avg_valid  averaged count and its one-cycle update strobe
//   overrun / overrun_clr  sticky overwrite flag and its clear
//   thresh_hi / thresh_lo  alarm set / clear levels
//   alarm                hysteretic rate alarm
module rate_capture_ack #(
   parameter int    AVG_LOG2     = 2,
   parameter string BACKPRESSURE = "TRUE"
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [24:0] count_in,
   input  logic        count_valid_in,
   output logic        count_ack,
   output logic [24:0] m_tdata,
   output logic        m_tvalid,
   input  logic        m_tready,
   output logic [24:0] avg_out,
   output logic        avg_valid,
   output logic        overrun,
   input  logic        overrun_clr,
   input  logic [24:0] thresh_hi,
   input  logic [24:0] thresh_lo,
   output logic        alarm
);

   localparam bit BP_EN = (BACKPRESSURE == "TRUE");
   localparam int ACC_W = 25 + AVG_LOG2;
   // A zero-width sample counter is not legal; with AVG_LOG2=0 every capture
   // is the last sample, so the 1-bit counter simply stays at zero.
   localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

   localparam logic [0:0] IDLE     = 1'b0;
   localparam logic [0:0] WAIT_CLR = 1'b1;

   logic [0:0]       state;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_sum;
   logic [CNT_W-1:0] sample_cnt;
   logic             slot_free;
   logic             capture;
   logic             last_sample;

   always_comb begin
      slot_free   = !m_tvalid || m_tready;
      capture     = (state == IDLE) && enable && count_valid_in && (slot_free || !BP_EN);
      acc_sum     = acc + ACC_W'(count_in);
      last_sample = (AVG_LOG2 == 0) || (sample_cnt == '1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         count_ack  <= 1'b0;
         m_tdata    <= '0;
         m_tvalid   <= 1'b0;
         avg_out    <= '0;
         avg_valid  <= 1'b0;
         overrun    <= 1'b0;
         alarm      <= 1'b0;
         acc        <= '0;
         sample_cnt <= '0;
      end else begin
         count_ack <= capture;
         avg_valid <= capture && last_sample;

         // WAIT_CLR holds until the ack has gone and the counter has dropped
         // its valid, so a stale valid is never counted twice.
         case (state)
            IDLE:     if (capture) state <= WAIT_CLR;
            WAIT_CLR: if (!count_ack && !count_valid_in) state <= IDLE;
            default:  state <= IDLE;
         endcase

         // A capture on the same edge as an accept keeps the slot full.
         if (capture) begin
            m_tdata  <= count_in;
            m_tvalid <= 1'b1;
         end else if (m_tready) begin
            m_tvalid <= 1'b0;
         end

         // Set has priority over clear.
         if (!BP_EN && capture && m_tvalid && !m_tready)
            overrun <= 1'b1;
         else if (overrun_clr)
            overrun <= 1'b0;

         if (capture) begin
            if (last_sample) begin
               avg_out    <= 25'(acc_sum >> AVG_LOG2);
               acc        <= '0;
               sample_cnt <= '0;
            end else begin
               acc        <= acc_sum;
               sample_cnt <= sample_cnt + CNT_W'(1);
            end

            // Set is tested first so it wins when thresh_lo > thresh_hi.
            if (count_in > thresh_hi)
               alarm <= 1'b1;
            else if (count_in < thresh_lo)
               alarm <= 1'b0;
         end
      end
   end

endmodule

// File: doc/rate_capture_ack.md
# rate_capture_ack

Downstream consumer for a DSP timed counter in acknowledge mode. It captures each completed interval count, returns the acknowledge that restarts the counter, and presents the count on a valid/ready output. Alongside the capture it keeps a power-of-two interval average, a sticky overrun flag and a hysteretic rate alarm. It sits between the counter and the register/readout logic in the same clock domain.

## Interface
- `AVG_LOG2`, default 2: average over 2^AVG_LOG2 captures; range 0–8.
- `BACKPRESSURE`, default "TRUE":
  - "TRUE": withhold the acknowledge until the output slot is free.
  - "FALSE": overwrite the slot and flag an overrun.
- `clk` input 1: sole clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `enable` input 1: captures are allowed only when high.
- `count_in` input 25: interval count from the counter.
- `count_valid_in` input 1: counter's level-held valid.
- `count_ack` output 1: one-cycle pulse; drives the counter's `rst`.
- `m_tdata` output 25: latest captured count.
- `m_tvalid` output 1: output slot holds a count.
- `m_tready` input 1: consumer accepts.
- `avg_out` output 25: averaged count.
- `avg_valid` output 1: one-cycle pulse when `avg_out` updates.
- `overrun` output 1: sticky flag; set when an un-accepted count is overwritten.
- `overrun_clr` input 1: clears `overrun`.
- `thresh_hi` input 25: alarm set level.
- `thresh_lo` input 25: alarm clear level.
- `alarm` output 1: hysteretic rate alarm.

## Operation
- **Reset.** `rst_n` low forces state to IDLE and clears every output and internal register: `count_ack`, `m_tvalid`, `m_tdata`, `avg_out`, `avg_valid`, `overrun`, `alarm`, the accumulator and the sample counter. Reset may arrive mid-interval; no pending capture survives it.
- **Slot free.** `slot_free = !m_tvalid || m_tready`.
- **Capture condition.**
  - BACKPRESSURE "TRUE": `capture = (state==IDLE) && enable && count_valid_in && slot_free`.
  - BACKPRESSURE "FALSE": `slot_free` is ignored.
- **States and transitions.**
  - IDLE → WAIT_CLR on `capture`.
  - WAIT_CLR → IDLE when `count_ack==0 && count_valid_in==0`.
  - WAIT_CLR never captures, so a stale valid is never double-counted.
- **On capture (same edge):**
  - `m_tdata <= count_in`, `m_tvalid <= 1`, `count_ack <= 1`.
  - The accumulator and the alarm update.
- **`count_ack`.** Exactly one cycle high per capture, never otherwise.
- **Output slot.**
  - `m_tvalid` clears on `m_tvalid && m_tready` unless a capture occurs on the same edge; a capture wins.
  - `m_tdata` is stable while `m_tvalid && !m_tready`, except for a BACKPRESSURE "FALSE" overwrite.
- **Overrun.**
  - Set on a capture while `m_tvalid && !m_tready` (BACKPRESSURE "FALSE" only).
  - `overrun_clr` clears it; if set and clear occur on the same edge, set wins.
- **Average.**
  - Accumulator is 25+AVG_LOG2 bits; sample counter is AVG_LOG2 bits.
  - Each capture adds `count_in`.
  - On the 2^AVG_LOG2-th capture: `avg_out <= (acc + count_in) >> AVG_LOG2` (truncating), `avg_valid <= 1` for one cycle, accumulator cleared.
  - AVG_LOG2=0: `avg_out` equals each capture and `avg_valid` pulses every capture.
- **Alarm.** Evaluated on capture only, with unsigned compares:
  - set if `count_in > thresh_hi`;
  - clear if `count_in < thresh_lo`;
  - otherwise hold.
  - If `thresh_lo > thresh_hi` and both conditions are true, set wins.
- **Enable.** `enable` low blocks new captures only. The counter stays held, since no ack is issued. An in-progress WAIT_CLR completes normally.

## Timing
- **Capture to outputs.** With the capture edge at E:
  - `m_tvalid`, `m_tdata` and `count_ack` are high in cycle E+1.
  - `avg_valid` and `alarm` update in cycle E+1.
- **Counter restart.** The counter samples `count_ack` at edge E+1, so its valid drops for cycle E+2.
  - WAIT_CLR exits at edge E+2 at the earliest, giving IDLE in cycle E+3.
  - Minimum capture spacing is therefore 3 cycles.
- **Backpressure.** With BACKPRESSURE "TRUE" and the consumer stalled, `count_ack` is withheld indefinitely and `count_valid_in` stays high. Capture happens on the same edge that `m_tready` is seen high, giving zero added bubble.
- **Combinational paths.** None from inputs to outputs; every output is registered.

## Test plan
- **Reset values.** Hold `rst_n` low mid-run → all outputs 0.
  - Release while `count_valid_in` is high → capture on the first enabled edge.
- **Basic capture.** `count_in`=25'd1234, valid high, `m_tready`=1 → `m_tdata`=1234 and one-cycle `count_ack` at E+1.
  - Valid deasserted at E+2 → no second ack.
- **Average.** AVG_LOG2=2, captures 10,20,30,41 → `avg_out`=25, with `avg_valid` pulsing only after the 4th.
  - Next 4 captures of 8 → `avg_out`=8.
- **Backpressure.** BACKPRESSURE "TRUE", `m_tready`=0 for 20 cycles with valid high → no `count_ack`, `m_tdata` held.
  - Raise `m_tready` → old count accepted and new capture on that same edge.
- **Overrun.** BACKPRESSURE "FALSE", `m_tready`=0, two captures (5, then 7) → `m_tdata`=7 and `overrun`=1.
  - `overrun_clr` on the same edge as a third overwrite → `overrun` stays 1.
- **Alarm hysteresis.** `thresh_hi`=100, `thresh_lo`=50; captures 101, 80, 49 → `alarm` 1, 1, 0.
  - Count of exactly 100 → no set.
